// File: rtl/multi_alarm_clock.sv
// 24-hour binary clock with NUM_ALARMS alarm channels, a ring auto-silence timeout and
// an optional snooze feature compiled in when ALARM_SNOOZE_EN is defined.
module multi_alarm_clock #(
  parameter int NUM_ALARMS   = 4,
  parameter int TICK_DIV     = 50000000,
  parameter int SNOOZE_SEC   = 300,
  parameter int RING_MAX_SEC = 60,
  localparam int IDX_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  run_clock,
  input  logic                  load_time,
  input  logic [7:0]            hrs_in,
  input  logic [7:0]            min_in,
  input  logic                  alarm_wr,
  input  logic [IDX_W-1:0]      alarm_idx,
  input  logic [7:0]            alarm_hrs,
  input  logic [7:0]            alarm_min,
  input  logic                  alarm_on,
  input  logic                  alarm_ack,
  input  logic                  snooze,
  output logic [7:0]            sec,
  output logic [7:0]            min,
  output logic [7:0]            hrs,
  output logic                  tick,
  output logic [NUM_ALARMS-1:0] alrm_vec,
  output logic                  alrm,
  output logic                  snoozing
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    RING_LAST  = 8'(RING_MAX_SEC - 1);

  function automatic logic time_ok(input logic [7:0] h, input logic [7:0] m);
    return (h <= 8'd23) && (m <= 8'd59);
  endfunction

  logic [PW-1:0]         presc_q, presc_d;
  logic [7:0]            sec_q, sec_d, min_q, min_d, hrs_q, hrs_d;
  logic                  tick_q, tick_d;
  logic [7:0]            al_hrs_q [NUM_ALARMS];
  logic [7:0]            al_hrs_d [NUM_ALARMS];
  logic [7:0]            al_min_q [NUM_ALARMS];
  logic [7:0]            al_min_d [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] al_on_q, al_on_d;
  logic [NUM_ALARMS-1:0] ring_q, ring_d;
  logic [7:0]            ring_cnt_q, ring_cnt_d;
  logic                  alrm_q, alrm_d;
  logic [NUM_ALARMS-1:0] match_s, wr_sel_s;
  logic                  load_ok_s, wrap_s, wr_ok_s;

`ifdef ALARM_SNOOZE_EN
  localparam logic [15:0] SNZ_LAST = 16'(SNOOZE_SEC - 1);
  logic                  snz_q, snz_d;
  logic [15:0]           snz_cnt_q, snz_cnt_d;
  logic [NUM_ALARMS-1:0] saved_q, saved_d;
`else
  logic unused_snooze_s;
  assign unused_snooze_s = snooze;
`endif

  // Prescaler and time-of-day counters; a valid load wins over a same-cycle wrap.
  always_comb begin
    presc_d   = presc_q;
    sec_d     = sec_q;
    min_d     = min_q;
    hrs_d     = hrs_q;
    tick_d    = 1'b0;
    load_ok_s = load_time && time_ok(hrs_in, min_in);
    wrap_s    = run_clock && (presc_q == PRESC_LAST);
    if (load_ok_s) begin
      presc_d = {PW{1'b0}};
      sec_d   = 8'd0;
      min_d   = min_in;
      hrs_d   = hrs_in;
    end else if (wrap_s) begin
      presc_d = {PW{1'b0}};
      tick_d  = 1'b1;
      if (sec_q == 8'd59) begin
        sec_d = 8'd0;
        if (min_q == 8'd59) begin
          min_d = 8'd0;
          if (hrs_q == 8'd23) begin
            hrs_d = 8'd0;
          end else begin
            hrs_d = hrs_q + 8'd1;
          end
        end else begin
          min_d = min_q + 8'd1;
        end
      end else begin
        sec_d = sec_q + 8'd1;
      end
    end else if (run_clock) begin
      presc_d = presc_q + PW'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  // Alarm channel configuration writes; the index is decoded so it never overruns the array.
  always_comb begin
    al_hrs_d = al_hrs_q;
    al_min_d = al_min_q;
    al_on_d  = al_on_q;
    wr_sel_s = {NUM_ALARMS{1'b0}};
    for (int c = 0; c < NUM_ALARMS; c++) begin
      if (alarm_idx == IDX_W'(c)) begin
        wr_sel_s[c] = 1'b1;
      end else begin
        wr_sel_s[c] = 1'b0;
      end
    end
    wr_ok_s = alarm_wr && time_ok(alarm_hrs, alarm_min) && (|wr_sel_s);
    for (int c = 0; c < NUM_ALARMS; c++) begin
      if (wr_ok_s && wr_sel_s[c]) begin
        al_hrs_d[c] = alarm_hrs;
        al_min_d[c] = alarm_min;
        al_on_d[c]  = alarm_on;
      end else begin
        al_hrs_d[c] = al_hrs_q[c];
        al_min_d[c] = al_min_q[c];
        al_on_d[c]  = al_on_q[c];
      end
    end
  end

  // A channel matches during the tick cycle that shows its hh:mm:00.
  always_comb begin
    match_s = {NUM_ALARMS{1'b0}};
    for (int c = 0; c < NUM_ALARMS; c++) begin
      match_s[c] = tick_q && al_on_q[c] && (sec_q == 8'd0) &&
                   (hrs_q == al_hrs_q[c]) && (min_q == al_min_q[c]);
    end
  end

  // Ring vector, auto-silence timer and snooze; later steps override earlier ones.
  always_comb begin
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
    snz_d      = snz_q;
    snz_cnt_d  = snz_cnt_q;
    saved_d    = saved_q;
`endif
    if (tick_q && (|ring_q)) begin
      if (ring_cnt_q == RING_LAST) begin
        ring_d     = {NUM_ALARMS{1'b0}};
        ring_cnt_d = 8'd0;
      end else begin
        ring_cnt_d = ring_cnt_q + 8'd1;
      end
    end else begin
      ring_cnt_d = ring_cnt_q;
    end
    // A match joining an active ring keeps the running timeout.
    if (|match_s) begin
      if (|ring_d) begin
        ring_cnt_d = ring_cnt_d;
      end else begin
        ring_cnt_d = 8'd0;
      end
      ring_d = ring_d | match_s;
    end else begin
      ring_d = ring_d;
    end
`ifdef ALARM_SNOOZE_EN
    if (tick_q && snz_q) begin
      if (snz_cnt_q == SNZ_LAST) begin
        ring_d     = ring_d | saved_q;
        saved_d    = {NUM_ALARMS{1'b0}};
        snz_d      = 1'b0;
        snz_cnt_d  = 16'd0;
        ring_cnt_d = 8'd0;
      end else begin
        snz_cnt_d = snz_cnt_q + 16'd1;
      end
    end else begin
      snz_cnt_d = snz_cnt_q;
    end
`endif
    if (wr_ok_s) begin
      ring_d = ring_d & ~wr_sel_s;
    end else begin
      ring_d = ring_d;
    end
`ifdef ALARM_SNOOZE_EN
    if (snooze && !alarm_ack && (|ring_q)) begin
      saved_d    = saved_d | ring_d;
      ring_d     = {NUM_ALARMS{1'b0}};
      snz_d      = 1'b1;
      snz_cnt_d  = 16'd0;
      ring_cnt_d = 8'd0;
    end else begin
      saved_d = saved_d;
    end
`endif
    if (alarm_ack) begin
      ring_d     = {NUM_ALARMS{1'b0}};
      ring_cnt_d = 8'd0;
`ifdef ALARM_SNOOZE_EN
      snz_d      = 1'b0;
      snz_cnt_d  = 16'd0;
      saved_d    = {NUM_ALARMS{1'b0}};
`endif
    end else begin
      ring_d = ring_d;
    end
    alrm_d = |ring_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      presc_q    <= {PW{1'b0}};
      sec_q      <= 8'd0;
      min_q      <= 8'd0;
      hrs_q      <= 8'd0;
      tick_q     <= 1'b0;
      for (int c = 0; c < NUM_ALARMS; c++) begin
        al_hrs_q[c] <= 8'd0;
        al_min_q[c] <= 8'd0;
      end
      al_on_q    <= {NUM_ALARMS{1'b0}};
      ring_q     <= {NUM_ALARMS{1'b0}};
      ring_cnt_q <= 8'd0;
      alrm_q     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_q      <= 1'b0;
      snz_cnt_q  <= 16'd0;
      saved_q    <= {NUM_ALARMS{1'b0}};
`endif
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hrs_q      <= hrs_d;
      tick_q     <= tick_d;
      al_hrs_q   <= al_hrs_d;
      al_min_q   <= al_min_d;
      al_on_q    <= al_on_d;
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
      alrm_q     <= alrm_d;
`ifdef ALARM_SNOOZE_EN
      snz_q      <= snz_d;
      snz_cnt_q  <= snz_cnt_d;
      saved_q    <= saved_d;
`endif
    end
  end

  assign sec      = sec_q;
  assign min      = min_q;
  assign hrs      = hrs_q;
  assign tick     = tick_q;
  assign alrm_vec = ring_q;
  assign alrm     = alrm_q;
`ifdef ALARM_SNOOZE_EN
  assign snoozing = snz_q;
`else
  assign snoozing = 1'b0;
`endif

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Randomised bench for multi_alarm_clock with a seconds-of-day reference model,
// plus directed scenarios pinned to hand-computed values.
module tb_multi_alarm_clock;

  localparam int TD   = 4;
  localparam int SNZ  = 3;
  localparam int RMAX = 5;
  localparam int NA   = 4;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, run_clock, load_time, alarm_wr, alarm_on, alarm_ack, snooze;
  logic [7:0] hrs_in, min_in, alarm_hrs, alarm_min;
  logic [1:0] alarm_idx;
  logic [7:0] sec, min, hrs;
  logic       tick, alrm, snoozing;
  logic [3:0] alrm_vec;

  multi_alarm_clock #(.NUM_ALARMS(NA), .TICK_DIV(TD), .SNOOZE_SEC(SNZ), .RING_MAX_SEC(RMAX)) dut (
    .CLK(clk), .reset(reset), .run_clock(run_clock), .load_time(load_time),
    .hrs_in(hrs_in), .min_in(min_in), .alarm_wr(alarm_wr), .alarm_idx(alarm_idx),
    .alarm_hrs(alarm_hrs), .alarm_min(alarm_min), .alarm_on(alarm_on),
    .alarm_ack(alarm_ack), .snooze(snooze), .sec(sec), .min(min), .hrs(hrs),
    .tick(tick), .alrm_vec(alrm_vec), .alrm(alrm), .snoozing(snoozing));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_gap = 0;
  bit chk_en = 1'b0;

  // Reference model: time as seconds since midnight, alarms as minute of day,
  // ring and snooze timers as ticks remaining.
  int       m_tod = 0, m_pc = 0, m_left = 0, m_snz_left = 0;
  bit       m_tick = 1'b0, m_snz = 1'b0;
  int       m_al_min [NA];
  bit       m_al_on [NA];
  logic [3:0] m_ring = 4'd0, m_saved = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] match;
    logic [3:0] r;
    int cur_min;
    match = 4'd0;
    if (reset) begin
      m_tod = 0; m_pc = 0; m_tick = 1'b0; m_ring = 4'd0; m_saved = 4'd0;
      m_left = 0; m_snz = 1'b0; m_snz_left = 0;
      for (int c = 0; c < NA; c++) begin
        m_al_min[c] = 0;
        m_al_on[c]  = 1'b0;
      end
    end else begin
      cur_min = m_tod / 60;
      if (m_tick && (m_tod % 60) == 0)
        for (int c = 0; c < NA; c++)
          if (m_al_on[c] && m_al_min[c] == cur_min) match[c] = 1'b1;
      r = m_ring;
      if (m_tick && r != 4'd0) begin
        m_left--;
        if (m_left == 0) r = 4'd0;
      end
      if (match != 4'd0) begin
        if (r == 4'd0) m_left = RMAX;
        r = r | match;
      end
      if (SNZ_EN && m_snz && m_tick) begin
        m_snz_left--;
        if (m_snz_left == 0) begin
          r = r | m_saved; m_saved = 4'd0; m_snz = 1'b0; m_left = RMAX;
        end
      end
      if (alarm_wr && alarm_hrs < 24 && alarm_min < 60) begin
        m_al_min[alarm_idx] = alarm_hrs * 60 + alarm_min;
        m_al_on[alarm_idx]  = alarm_on;
        r[alarm_idx] = 1'b0;
      end
      if (SNZ_EN && snooze && !alarm_ack && m_ring != 4'd0) begin
        m_saved = m_saved | r; r = 4'd0; m_snz = 1'b1; m_snz_left = SNZ; m_left = RMAX;
      end
      if (alarm_ack) begin
        r = 4'd0; m_snz = 1'b0; m_saved = 4'd0;
      end
      m_ring = r;
      if (load_time && hrs_in < 24 && min_in < 60) begin
        m_tod = hrs_in * 3600 + min_in * 60; m_pc = 0; m_tick = 1'b0;
      end else if (run_clock) begin
        if (m_pc == TD - 1) begin
          m_pc = 0; m_tick = 1'b1; m_tod = (m_tod + 1) % 86400;
        end else begin
          m_pc++; m_tick = 1'b0;
        end
      end else begin
        m_tick = 1'b0;
      end
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("sec", sec, m_tod % 60);
      chk("min", min, (m_tod / 60) % 60);
      chk("hrs", hrs, m_tod / 3600);
      chk("tick", tick, m_tick);
      chk("alrm_vec", alrm_vec, m_ring);
      chk("alrm", alrm, m_ring != 4'd0);
      chk("snoozing", snoozing, m_snz);
    end
  end

  task automatic wait_ticks(input int n);
    int seen = 0;
    int budget = n * TD * 3 + 20;
    int last = -1;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (tick) begin
        if (last >= 0) last_gap = cyc - last;
        last = cyc;
        seen++;
      end
    end
    chk("tick_wait", seen, n);
  endtask

  task automatic do_load(input int h, input int m);
    load_time = 1'b1; hrs_in = 8'(h); min_in = 8'(m);
    @(negedge clk);
    load_time = 1'b0;
  endtask

  task automatic do_wr(input int idx, input int h, input int m, input bit on);
    alarm_wr = 1'b1; alarm_idx = 2'(idx); alarm_hrs = 8'(h); alarm_min = 8'(m); alarm_on = on;
    @(negedge clk);
    alarm_wr = 1'b0;
  endtask

  task automatic do_ack(input bit with_snooze);
    alarm_ack = 1'b1; snooze = with_snooze;
    @(negedge clk);
    alarm_ack = 1'b0; snooze = 1'b0;
  endtask

  task automatic do_snooze();
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
  endtask

  initial begin
    int guard;
    int base;
    reset = 1'b1; run_clock = 1'b0; load_time = 1'b0; alarm_wr = 1'b0; alarm_on = 1'b0;
    alarm_ack = 1'b0; snooze = 1'b0; hrs_in = 8'd0; min_in = 8'd0;
    alarm_hrs = 8'd0; alarm_min = 8'd0; alarm_idx = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_hms", {8'd0, hrs, min, sec}, 32'd0);
    chk("reset_vec", alrm_vec, 4'd0);
    chk("reset_tick", tick, 1'b0);

    // Roll over midnight.
    do_load(23, 59);
    chk("load_hms", {8'd0, hrs, min, sec}, {8'd0, 8'd23, 8'd59, 8'd0});
    run_clock = 1'b1;
    wait_ticks(60);
    chk("midnight_hms", {8'd0, hrs, min, sec}, 32'd0);
    chk("tick_gap", last_gap, 4);

    // Alarm at 00:00 with auto-silence.
    run_clock = 1'b0;
    do_wr(0, 0, 0, 1'b1);
    do_load(23, 59);
    run_clock = 1'b1;
    wait_ticks(60);
    @(negedge clk);
    chk("ring_midnight", alrm_vec, 4'b0001);
    wait_ticks(5);
    chk("ring_before_silence", alrm_vec, 4'b0001);
    @(negedge clk);
    chk("ring_silenced", alrm_vec, 4'b0000);

    // Two channels together, then dismiss.
    do_wr(1, 7, 30, 1'b1);
    do_wr(2, 7, 30, 1'b1);
    do_load(7, 29);
    wait_ticks(60);
    @(negedge clk);
    chk("ring_pair", alrm_vec, 4'b0110);
    do_ack(1'b0);
    chk("ack_clears", alrm_vec, 4'b0000);

    // Snooze behaviour.
    do_load(7, 29);
    wait_ticks(60);
    @(negedge clk);
    chk("ring_pair2", alrm_vec, 4'b0110);
    do_snooze();
    if (SNZ_EN) begin
      chk("snooze_alrm", alrm, 1'b0);
      chk("snooze_flag", snoozing, 1'b1);
      wait_ticks(3);
      @(negedge clk);
      chk("snooze_restore", alrm_vec, 4'b0110);
      chk("snooze_done", snoozing, 1'b0);
      do_snooze();
      chk("snooze_again", snoozing, 1'b1);
      do_ack(1'b1);
      chk("ack_snz_alrm", alrm, 1'b0);
      chk("ack_snz_flag", snoozing, 1'b0);
      wait_ticks(4);
      @(negedge clk);
      chk("no_restore", alrm_vec, 4'b0000);
    end else begin
      chk("snooze_ignored", alrm_vec, 4'b0110);
      chk("snoozing_tied", snoozing, 1'b0);
      do_ack(1'b1);
      chk("ack_snz_alrm", alrm, 1'b0);
    end

    // Invalid loads, reset mid-ring, load against a tick.
    run_clock = 1'b0;
    do_load(12, 34);
    do_load(24, 0);
    chk("bad_load_hr", {hrs, min, sec}, {8'd12, 8'd34, 8'd0});
    do_load(10, 60);
    chk("bad_load_min", {hrs, min, sec}, {8'd12, 8'd34, 8'd0});
    do_wr(3, 12, 35, 1'b1);
    run_clock = 1'b1;
    wait_ticks(60);
    @(negedge clk);
    chk("ring_ch3", alrm_vec, 4'b1000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ring_hms", {8'd0, hrs, min, sec}, 32'd0);
    chk("rst_ring_out", {tick, alrm, snoozing, alrm_vec}, 7'd0);
    guard = 0;
    while (m_pc != TD - 1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("wrap_found", m_pc, TD - 1);
    do_load(5, 6);
    chk("load_vs_tick", {hrs, min, sec}, {8'd5, 8'd6, 8'd0});
    chk("load_vs_tick_t", tick, 1'b0);

    // Randomised phase.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 1999) == 0);
      run_clock = ($urandom_range(0, 19) != 0);
      load_time = ($urandom_range(0, 299) == 0);
      hrs_in    = 8'($urandom_range(0, 26));
      min_in    = 8'($urandom_range(0, 63));
      alarm_wr  = ($urandom_range(0, 39) == 0);
      alarm_idx = 2'($urandom_range(0, 3));
      base      = m_tod / 60 + int'($urandom_range(0, 2));
      alarm_hrs = ($urandom_range(0, 9) == 0) ? 8'd24 : 8'((base / 60) % 24);
      alarm_min = 8'(base % 60);
      alarm_on  = ($urandom_range(0, 3) != 0);
      alarm_ack = ($urandom_range(0, 119) == 0);
      snooze    = ($urandom_range(0, 29) == 0);
    end
    @(negedge clk);
    reset = 1'b0; load_time = 1'b0; alarm_wr = 1'b0; alarm_ack = 1'b0; snooze = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 SHALL have parameter NUM_ALARMS, default 4, meaning the number of independent alarm channels (1..16).
REQ-002 SHALL have parameter TICK_DIV, default 50000000, meaning CLK cycles per second tick (>=2).
REQ-003 SHALL have parameter SNOOZE_SEC, default 300, meaning snooze delay in seconds (1..65535).
REQ-004 SHALL have parameter RING_MAX_SEC, default 60, meaning auto-silence timeout in seconds (1..255).
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port run_clock, input, 1 bit: enables the prescaler and timekeeping.
REQ-008 SHALL have ports load_time (input, 1 bit, pulse), hrs_in (input, 8 bits) and min_in (input, 8 bits), all binary.
REQ-009 SHALL have ports alarm_wr (input, 1 bit, pulse), alarm_idx (input, $clog2(NUM_ALARMS) bits, min 1), alarm_hrs (input, 8 bits), alarm_min (input, 8 bits) and alarm_on (input, 1 bit).
REQ-010 SHALL have ports alarm_ack (input, 1 bit, pulse: dismiss) and snooze (input, 1 bit, pulse).
REQ-011 SHALL have ports sec, min and hrs (output, 8 bits each, binary) and tick (output, 1 bit, one-cycle pulse per second).
REQ-012 SHALL have ports alrm_vec (output, NUM_ALARMS bits: ringing channels), alrm (output, 1 bit: OR of alrm_vec) and snoozing (output, 1 bit).

Function
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 while run_clock=1, hold its value while run_clock=0, and assert tick for the cycle in which it wraps.
REQ-014 On tick, sec SHALL increment; 59->0 SHALL carry into min; min 59->0 SHALL carry into hrs; hrs 23->0.
REQ-015 load_time with hrs_in<=23 and min_in<=59 SHALL set hrs/min to the inputs, set sec=0 and clear the prescaler, with outputs valid the next cycle; an out-of-range load SHALL be ignored completely.
REQ-016 load_time SHALL take priority over a tick in the same cycle; that tick is discarded.
REQ-017 alarm_wr SHALL store {alarm_hrs, alarm_min, alarm_on} into channel alarm_idx and clear that channel's ringing bit; out-of-range values or an index >= NUM_ALARMS SHALL be ignored.
REQ-018 A channel SHALL start ringing (alrm_vec bit set) one cycle after the tick that makes the time hh:mm:00 with hh:mm equal to its stored value and alarm_on=1; 00:00 is a valid alarm time.
REQ-019 A ringing bit SHALL stay set until alarm_ack, snooze, alarm_wr to that channel, reset, or RING_MAX_SEC ticks after ringing starts (auto-silence, which clears all bits).
REQ-020 alarm_ack SHALL clear all ringing bits, cancel any pending snooze and clear snoozing on the next cycle.
REQ-021 alarm_ack and snooze in the same cycle SHALL behave as alarm_ack alone.
REQ-022 Channels matching on the same tick SHALL ring together; a match during an active ring SHALL OR into alrm_vec and SHALL NOT restart the timeout.
REQ-023 Ringing and matching SHALL advance only on ticks; with run_clock=0, no new matches occur and timers freeze.

Reset
REQ-024 reset SHALL set sec/min/hrs=0, clear the prescaler, tick=0, alrm_vec=0, alrm=0, snoozing=0, all snooze and ring timers=0, and every channel to 00:00 with alarm_on=0.
REQ-025 reset SHALL take priority over every other input in the same cycle, including mid-ring and mid-snooze.

Configuration
REQ-026 With macro ALARM_SNOOZE_EN defined: snooze while alrm=1 SHALL save alrm_vec, clear it, set snoozing=1 and count SNOOZE_SEC ticks, then restore the saved vector, clear snoozing and restart the ring timeout; snooze while alrm=0 SHALL be ignored.
REQ-027 Without ALARM_SNOOZE_EN: the snooze input SHALL be ignored, snoozing SHALL be tied to 0 and no snooze state SHALL be synthesised.

Verification (TICK_DIV=4, SNOOZE_SEC=3, RING_MAX_SEC=5)
REQ-028 load_time 23:59, run 60 ticks -> hrs:min:sec = 00:00:00 with tick spaced 4 cycles apart.
REQ-029 alarm 0 set to 00:00 on, time loaded 23:59, run 60 ticks -> alrm_vec=0001 one cycle after the tick; after 5 more ticks alrm_vec=0.
REQ-030 alarms 1 and 2 both set to 07:30 -> alrm_vec=0110 simultaneously; alarm_ack -> alrm_vec=0 next cycle.
REQ-031 (ALARM_SNOOZE_EN) ring, then snooze -> alrm=0 and snoozing=1; after 3 ticks alrm_vec restored; alarm_ack together with snooze -> alrm=0, snoozing=0.
REQ-032 load_time 24:00 -> time unchanged; reset asserted mid-ring -> all outputs 0 next cycle; load_time coincident with tick -> sec=0.
